// File: rtl/bist_fail_logger_if.sv
// bist_fail_logger_if: compare, readout and status bundle; BIST_FIRST_FAIL_EN adds first-fail capture signals
interface bist_fail_logger_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
);
    logic              start;
    logic              cmp_valid;
    logic [ADDR_W-1:0] cmp_addr;
    logic [DATA_W-1:0] data_t;
    logic [DATA_W-1:0] ramout;
    logic              gt;
    logic              eq;
    logic              lt;
    logic              test_done;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_exp;
    logic [DATA_W-1:0] rd_act;
    logic              rd_dir;
    logic              fifo_empty;
    logic              fifo_full;
    logic              overflow;
    logic              cmp_err;
    logic [CNT_W-1:0]  fail_count;
    logic              busy;
    logic              done;
    logic              pass;
`ifdef BIST_FIRST_FAIL_EN
    logic              first_fail_valid;
    logic [ADDR_W-1:0] first_fail_addr;
    logic [DATA_W-1:0] first_fail_act;
`endif
    modport master (
        output start, cmp_valid, cmp_addr, data_t, ramout, gt, eq, lt, test_done, rd_en,
        input  rd_addr, rd_exp, rd_act, rd_dir, fifo_empty, fifo_full, overflow, cmp_err,
               fail_count, busy, done, pass
`ifdef BIST_FIRST_FAIL_EN
        , input first_fail_valid, first_fail_addr, first_fail_act
`endif
    );
    modport slave (
        input  start, cmp_valid, cmp_addr, data_t, ramout, gt, eq, lt, test_done, rd_en,
        output rd_addr, rd_exp, rd_act, rd_dir, fifo_empty, fifo_full, overflow, cmp_err,
               fail_count, busy, done, pass
`ifdef BIST_FIRST_FAIL_EN
        , output first_fail_valid, first_fail_addr, first_fail_act
`endif
    );
endinterface

// File: rtl/bist_fail_logger.sv
// bist_fail_logger: qualifies BIST compares, logs failures into a FWFT FIFO, reports done/pass; BIST_FIRST_FAIL_EN adds first-fail capture
module bist_fail_logger #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input logic clk,
    input logic rst_n,
    bist_fail_logger_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int RW = ADDR_W + 2 * DATA_W + 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state_q, state_d;
    logic [RW-1:0] mem_q [DEPTH];
    logic [RW-1:0] mem_d [DEPTH];
    logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [PW:0] cnt_q, cnt_d;
    logic fifo_empty_q, fifo_empty_d, fifo_full_q, fifo_full_d;
    logic overflow_q, overflow_d, cmp_err_q, cmp_err_d;
    logic [CNT_W-1:0] fail_count_q, fail_count_d;
    logic legal, fail, illegal, pop, push;
`ifdef BIST_FIRST_FAIL_EN
    logic ff_valid_q, ff_valid_d;
    logic [ADDR_W-1:0] ff_addr_q, ff_addr_d;
    logic [DATA_W-1:0] ff_act_q, ff_act_d;
`endif
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else state_q <= state_d;
    end
    always_comb begin
        state_d = bus.start ? RUN : (state_q == RUN && bus.test_done) ? DONE : state_q;
    end
    always_comb begin
        bus.busy = state_q == RUN;
        bus.done = state_q == DONE;
        bus.pass = state_q == DONE && fail_count_q == '0 && !cmp_err_q;
    end
    // start wins over a same-cycle compare; a full FIFO still accepts if it is popped this cycle
    always_comb begin
        legal = (bus.gt ^ bus.eq ^ bus.lt) && !(bus.gt && bus.eq && bus.lt);
        fail = state_q == RUN && !bus.start && bus.cmp_valid && !(legal && bus.eq);
        illegal = fail && !legal;
        pop = bus.rd_en && !fifo_empty_q;
        push = fail && (!fifo_full_q || pop);
    end
    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wp_q] = {bus.cmp_addr, bus.data_t, bus.ramout, legal && bus.gt};
        wp_d = bus.start ? '0 : wp_q + PW'(push);
        rp_d = bus.start ? '0 : rp_q + PW'(pop);
        cnt_d = bus.start ? '0 : cnt_q + (PW + 1)'(push) - (PW + 1)'(pop);
        fifo_empty_d = cnt_d == '0;
        fifo_full_d = cnt_d == (PW + 1)'(DEPTH);
        overflow_d = !bus.start && (overflow_q || (fail && !push));
        cmp_err_d = !bus.start && (cmp_err_q || illegal);
        fail_count_d = bus.start ? '0 : fail_count_q + CNT_W'(fail && !(&fail_count_q));
    end
    always_comb begin
        {bus.rd_addr, bus.rd_exp, bus.rd_act, bus.rd_dir} = fifo_empty_q ? '0 : mem_q[rp_q];
        bus.fifo_empty = fifo_empty_q;
        bus.fifo_full = fifo_full_q;
        bus.overflow = overflow_q;
        bus.cmp_err = cmp_err_q;
        bus.fail_count = fail_count_q;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
            wp_q <= '0;
            rp_q <= '0;
            cnt_q <= '0;
            fifo_empty_q <= 1'b1;
            fifo_full_q <= 1'b0;
            overflow_q <= 1'b0;
            cmp_err_q <= 1'b0;
            fail_count_q <= '0;
        end else begin
            mem_q <= mem_d;
            wp_q <= wp_d;
            rp_q <= rp_d;
            cnt_q <= cnt_d;
            fifo_empty_q <= fifo_empty_d;
            fifo_full_q <= fifo_full_d;
            overflow_q <= overflow_d;
            cmp_err_q <= cmp_err_d;
            fail_count_q <= fail_count_d;
        end
    end
`ifdef BIST_FIRST_FAIL_EN
    // first failure is captured independently of FIFO space
    always_comb begin
        ff_valid_d = !bus.start && (ff_valid_q || fail);
        ff_addr_d = bus.start ? '0 : (fail && !ff_valid_q) ? bus.cmp_addr : ff_addr_q;
        ff_act_d = bus.start ? '0 : (fail && !ff_valid_q) ? bus.ramout : ff_act_q;
        bus.first_fail_valid = ff_valid_q;
        bus.first_fail_addr = ff_addr_q;
        bus.first_fail_act = ff_act_q;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ff_valid_q <= 1'b0;
            ff_addr_q <= '0;
            ff_act_q <= '0;
        end else begin
            ff_valid_q <= ff_valid_d;
            ff_addr_q <= ff_addr_d;
            ff_act_q <= ff_act_d;
        end
    end
`endif
endmodule

// File: tb/tb_bist_fail_logger.sv
// tb_bist_fail_logger: directed self-checking bench for bist_fail_logger
module tb_bist_fail_logger;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int errors = 0;
    int checks = 0;
    bist_fail_logger_if #(.ADDR_W(8), .DATA_W(8), .CNT_W(16)) bus ();
    bist_fail_logger #(.ADDR_W(8), .DATA_W(8), .DEPTH(4), .CNT_W(16)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic idle();
        bus.start = 0; bus.cmp_valid = 0; bus.cmp_addr = 0; bus.data_t = 0; bus.ramout = 0;
        bus.gt = 0; bus.eq = 0; bus.lt = 0; bus.test_done = 0; bus.rd_en = 0;
    endtask
    task automatic cmp(input logic [7:0] a, input logic [7:0] e, input logic [7:0] r,
                       input logic g, input logic q, input logic l);
        bus.cmp_valid = 1; bus.cmp_addr = a; bus.data_t = e; bus.ramout = r;
        bus.gt = g; bus.eq = q; bus.lt = l;
    endtask
    task automatic do_start();
        idle(); bus.start = 1; tick(); idle();
    endtask
    initial begin
        idle();
        tick(); tick();
        chk("rst_empty", bus.fifo_empty, 1);
        chk("rst_full", bus.fifo_full, 0);
        chk("rst_ovf", bus.overflow, 0);
        chk("rst_err", bus.cmp_err, 0);
        chk("rst_cnt", bus.fail_count, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_pass", bus.pass, 0);
        chk("rst_rdaddr", bus.rd_addr, 0);
        rst_n = 1;
        cmp(8'h01, 8'h11, 8'h22, 0, 0, 1); tick(); idle();
        chk("idle_ignored", bus.fail_count, 0);
        do_start();
        chk("start_busy", bus.busy, 1);
        for (int i = 0; i < 16; i++) begin
            cmp(i[7:0], i[7:0], i[7:0], 0, 1, 0);
            bus.test_done = (i == 15);
            tick();
        end
        idle();
        chk("allpass_cnt", bus.fail_count, 0);
        chk("allpass_empty", bus.fifo_empty, 1);
        chk("allpass_done", bus.done, 1);
        chk("allpass_pass", bus.pass, 1);
        chk("allpass_busy", bus.busy, 0);
        cmp(8'h02, 8'h11, 8'h22, 0, 0, 1); tick(); idle();
        chk("done_ignored", bus.fail_count, 0);
        do_start();
        chk("restart_done", bus.done, 0);
        chk("restart_pass", bus.pass, 0);
        cmp(8'h3A, 8'h55, 8'h54, 1, 0, 0); tick(); idle();
        chk("single_cnt", bus.fail_count, 1);
        chk("single_addr", bus.rd_addr, 8'h3A);
        chk("single_exp", bus.rd_exp, 8'h55);
        chk("single_act", bus.rd_act, 8'h54);
        chk("single_dir", bus.rd_dir, 1);
        chk("single_empty", bus.fifo_empty, 0);
        do_start();
        chk("start_clr_empty", bus.fifo_empty, 1);
        for (int i = 1; i <= 5; i++) begin
            cmp(i[7:0], 8'h10, 8'h20, 0, 0, 1);
            tick();
        end
        idle();
        chk("five_full", bus.fifo_full, 1);
        chk("five_ovf", bus.overflow, 1);
        chk("five_cnt", bus.fail_count, 5);
        chk("five_dir", bus.rd_dir, 0);
        chk("five_act", bus.rd_act, 8'h20);
`ifdef BIST_FIRST_FAIL_EN
        chk("ff_valid", bus.first_fail_valid, 1);
        chk("ff_addr", bus.first_fail_addr, 1);
        chk("ff_act", bus.first_fail_act, 8'h20);
`endif
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("pop_addr%0d", i), bus.rd_addr, i);
            bus.rd_en = 1; tick(); idle();
        end
        chk("drain_empty", bus.fifo_empty, 1);
        chk("drain_rdaddr", bus.rd_addr, 0);
        bus.rd_en = 1; tick(); idle();
        chk("pop_empty_ignored", bus.fifo_empty, 1);
        do_start();
        for (int i = 1; i <= 4; i++) begin
            cmp(i[7:0], 8'h10, 8'h20, 0, 0, 1);
            tick();
        end
        idle();
        chk("fill_full", bus.fifo_full, 1);
        cmp(8'h10, 8'h40, 8'h30, 1, 0, 0); bus.rd_en = 1; tick(); idle();
        chk("pushpop_ovf", bus.overflow, 0);
        chk("pushpop_full", bus.fifo_full, 1);
        chk("pushpop_head", bus.rd_addr, 2);
        chk("pushpop_cnt", bus.fail_count, 5);
        for (int i = 0; i < 3; i++) begin
            bus.rd_en = 1; tick(); idle();
        end
        chk("last_addr", bus.rd_addr, 8'h10);
        chk("last_dir", bus.rd_dir, 1);
        do_start();
        cmp(8'h77, 8'h12, 8'h34, 1, 0, 1); tick(); idle();
        chk("illegal_err", bus.cmp_err, 1);
        chk("illegal_cnt", bus.fail_count, 1);
        chk("illegal_dir", bus.rd_dir, 0);
        chk("illegal_addr", bus.rd_addr, 8'h77);
        bus.test_done = 1; tick(); idle();
        chk("illegal_done", bus.done, 1);
        chk("illegal_pass", bus.pass, 0);
        do_start();
        cmp(8'h21, 8'h01, 8'h02, 0, 0, 1); tick(); idle();
        chk("pre_restart_cnt", bus.fail_count, 1);
        cmp(8'h99, 8'h01, 8'h02, 0, 0, 1); bus.start = 1; tick(); idle();
        chk("midrun_empty", bus.fifo_empty, 1);
        chk("midrun_cnt", bus.fail_count, 0);
        chk("midrun_ovf", bus.overflow, 0);
        chk("midrun_err", bus.cmp_err, 0);
        chk("midrun_busy", bus.busy, 1);
`ifdef BIST_FIRST_FAIL_EN
        chk("midrun_ffv", bus.first_fail_valid, 0);
        chk("midrun_ffa", bus.first_fail_addr, 0);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bist_fail_logger.md
Name: bist_fail_logger

Overview:
Downstream consumer of the BIST comparator. Each cycle the march controller strobes a compare, and this block qualifies the gt/eq/lt result. On a mismatch it logs a failure record {address, expected, actual, direction} into a small first-word-fall-through FIFO and counts failures. At end of test it reports done/pass status for readout by the test host.

Parameters:
ADDR_W, 8, SRAM address width
DATA_W, 8, data width (matches comparator byte)
DEPTH, 4, failure FIFO entries (power of 2, >=2)
CNT_W, 16, failure counter width

Ports:
clk  input  1  clock, all logic rising-edge
rst_n  input  1  synchronous active-low reset
start  input  1  begin session; clears FIFO, counters, flags
cmp_valid  input  1  compare strobe from march controller
cmp_addr  input  ADDR_W  address of compared word
data_t  input  DATA_W  expected data (same value fed to comparator)
ramout  input  DATA_W  actual memory data
gt  input  1  comparator: data_t > ramout
eq  input  1  comparator: equal
lt  input  1  comparator: data_t < ramout
test_done  input  1  march sequence complete
rd_en  input  1  pop head record
rd_addr  output  ADDR_W  head record address
rd_exp  output  DATA_W  head record expected data
rd_act  output  DATA_W  head record actual data
rd_dir  output  1  head record: 1 = expected > actual, 0 = expected < actual or illegal
fifo_empty  output  1  no records held
fifo_full  output  1  DEPTH records held
overflow  output  1  sticky: a failure record was dropped
cmp_err  output  1  sticky: illegal gt/eq/lt encoding seen
fail_count  output  CNT_W  total failures, saturating
busy  output  1  FSM in RUN
done  output  1  FSM in DONE
pass  output  1  valid in DONE: fail_count==0 and cmp_err==0

Behaviour:
- Reset (rst_n=0 at clk edge): FSM=IDLE; FIFO empty; rd_* = 0; fifo_empty=1, fifo_full=0, overflow=0, cmp_err=0, fail_count=0, busy=0, done=0, pass=0.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on start.
  - RUN -> DONE on test_done.
  - DONE -> RUN on start.
  - start in any state, including RUN: clears FIFO, fail_count, overflow, cmp_err and enters RUN.
- Start precedence: start has priority over cmp_valid and test_done in the same cycle. The compare is dropped and test_done is ignored.
- Compare qualification: cmp_valid is honoured only in RUN and ignored in IDLE/DONE.
  - Legal encoding = exactly one of gt/eq/lt set.
  - Failure = cmp_valid and not (legal and eq).
  - Illegal encoding sets cmp_err and counts as a failure with rd_dir=0.
- Failure effects, registered and visible one cycle after the cmp_valid edge:
  - fail_count += 1, saturating at 2^CNT_W-1.
  - Record pushed if FIFO not full, or if full and popped in the same cycle. Otherwise the record is dropped and overflow is set.
- Completion: cmp_valid and test_done in the same RUN cycle logs the compare, then enters DONE. done/pass assert the cycle after test_done.
- FIFO (FWFT):
  - rd_* always shows the head record while !fifo_empty, and holds 0 when empty.
  - rd_en pops the head; rd_en while empty is ignored. rd_en is legal in any state.
  - Simultaneous push and pop: both occur. Occupancy is unchanged, and the head advances to the next record, or to the new record if only one was held.
  - Pointers wrap modulo DEPTH. fifo_full/fifo_empty are registered, derived from a (log2(DEPTH)+1)-bit occupancy count.
- pass is 0 outside DONE.

Optional Feature:
BIST_FIRST_FAIL_EN
- Defined: adds outputs first_fail_valid (1), first_fail_addr (ADDR_W) and first_fail_act (DATA_W).
  - Captures the first failure of the session regardless of FIFO overflow.
  - Captured values hold until start or reset, which clear all three to 0.
  - Capture timing matches fail_count.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset then start, 16 compares with eq=1, then test_done -> fail_count=0, fifo_empty=1, done=1, pass=1 one cycle after test_done.
- Single failure: cmp_addr=0x3A, data_t=0x55, ramout=0x54, gt=1 -> next cycle fail_count=1; rd_addr=0x3A, rd_exp=0x55, rd_act=0x54, rd_dir=1; fifo_empty=0.
- Five failures (addr 1..5, DEPTH=4) with no reads -> fifo_full=1, overflow=1, fail_count=5. Four pops return addr 1,2,3,4, then fifo_empty=1.
- Full FIFO plus failure at addr 0x10 with rd_en in the same cycle -> overflow stays 0, fifo_full stays 1, head moves to second record, last record is 0x10.
- Illegal encoding gt=1, lt=1 with cmp_valid -> cmp_err=1, fail_count=1, rd_dir=0. After test_done, pass=0.
- start asserted mid-RUN together with cmp_valid on a failure -> next cycle FIFO empty, fail_count=0, overflow=0, busy=1. The compare is not logged. With BIST_FIRST_FAIL_EN defined, first_fail_valid=0.
